// File: rtl/calc_sequencer_pkg.sv
// calc_sequencer_pkg: shared FSM states, opcode encodings and default width for the hex calculator.
package calc_sequencer_pkg;
    localparam int CALC_WIDTH = 16;
    localparam logic [1:0] ADD      = 2'b00;
    localparam logic [1:0] MULTIPLY = 2'b01;
    localparam logic [1:0] SUBTRACT = 2'b10;
    typedef enum logic [1:0] {ENTRY_A, ENTRY_B, CALC, RESULT} state_t;
endpackage

// File: rtl/calc_multiplier.sv
// calc_multiplier: iterative shift-add multiplier, one multiplier bit per cycle, abortable by clr.
module calc_multiplier
    import calc_sequencer_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [2*WIDTH-1:0] mcand, prod;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               running;
    // product is the accumulator after this cycle's step, so it is final in the done cycle
    assign product = prod + (mplier[0] ? mcand : '0);
    assign done    = running && cnt == CW'(1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand   <= '0;
            prod    <= '0;
            mplier  <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (clr) begin
            mcand   <= '0;
            prod    <= '0;
            mplier  <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            mcand   <= {{WIDTH{1'b0}}, a};
            prod    <= '0;
            mplier  <= b;
            cnt     <= CW'(WIDTH);
            running <= 1'b1;
        end else if (running) begin
            prod    <= product;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            cnt     <= cnt - CW'(1);
            running <= cnt != CW'(1);
        end
    end
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-strobe driven operand entry, operator sequencing and add/sub/multiply control.
module calc_sequencer
    import calc_sequencer_pkg::*;
#(
    parameter int WIDTH  = CALC_WIDTH,
    parameter int DIGITS = WIDTH / 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             newhex,
    input  logic [3:0]       hexcode,
    input  logic             newop,
    input  logic [1:0]       opcode,
    input  logic             eq,
    input  logic             bs,
    input  logic             ca,
    output logic [WIDTH-1:0] display,
    output logic             busy,
    output logic             ovf,
    output logic             entry_b
);
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] MAXC = CW'(DIGITS);
    state_t             state, d_state;
    logic [WIDTH-1:0]   operand, d_operand, acc, d_acc, d_display, result;
    logic [CW-1:0]      count, d_count;
    logic [1:0]         op, d_op, pend, d_pend;
    logic               chain, d_chain, d_ovf, res_ovf, start, mul_done;
    logic [WIDTH:0]     sum, diff;
    logic [2*WIDTH-1:0] mprod;
    calc_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk(clk), .reset(reset), .clr(ca), .start(start),
        .a(acc), .b(operand), .done(mul_done), .product(mprod)
    );
    assign sum     = {1'b0, acc} + {1'b0, operand};
    assign diff    = {1'b0, acc} - {1'b0, operand};
    assign result  = op == MULTIPLY ? mprod[WIDTH-1:0] : op == SUBTRACT ? diff[WIDTH-1:0] : sum[WIDTH-1:0];
    assign res_ovf = op == MULTIPLY ? |mprod[2*WIDTH-1:WIDTH] : op == SUBTRACT ? diff[WIDTH] : sum[WIDTH];
    assign busy    = state == CALC;
    assign entry_b = state == ENTRY_B;
    always_comb begin
        d_state   = state;
        d_operand = operand;
        d_count   = count;
        d_acc     = acc;
        d_op      = op;
        d_pend    = pend;
        d_chain   = chain;
        d_ovf     = ovf;
        start     = 1'b0;
        if (ca) begin
            d_state   = ENTRY_A;
            d_operand = '0;
            d_count   = '0;
            d_acc     = '0;
            d_op      = ADD;
            d_ovf     = 1'b0;
            d_chain   = 1'b0;
        end else if (state == CALC) begin
            if (op != MULTIPLY || mul_done) begin
                d_acc     = result;
                d_ovf     = res_ovf;
                d_operand = '0;
                d_count   = '0;
                d_state   = chain ? ENTRY_B : RESULT;
                d_op      = chain ? pend : op;
                d_chain   = 1'b0;
            end
        end else if (state == RESULT) begin
            // bs/eq are ignored here but still outrank newop/newhex
            if (!bs && !eq && newop) begin
                d_op    = opcode;
                d_state = ENTRY_B;
            end else if (!bs && !eq && newhex) begin
                d_operand = {{(WIDTH-4){1'b0}}, hexcode};
                d_count   = CW'(1);
                d_state   = ENTRY_A;
            end
        end else if (bs) begin
            if (count != '0) begin
                d_operand = operand >> 4;
                d_count   = count - CW'(1);
            end
        end else if (eq) begin
            if (state == ENTRY_B && count != '0) begin
                d_state = CALC;
                start   = op == MULTIPLY;
            end
        end else if (newop) begin
            if (state == ENTRY_A) begin
                d_acc     = operand;
                d_op      = opcode;
                d_operand = '0;
                d_count   = '0;
                d_state   = ENTRY_B;
            end else if (count == '0) begin
                d_op = opcode;
            end else begin
                d_state = CALC;
                d_pend  = opcode;
                d_chain = 1'b1;
                start   = op == MULTIPLY;
            end
        end else if (newhex && count != MAXC) begin
            d_operand = {operand[WIDTH-5:0], hexcode};
            d_count   = count + CW'(1);
        end
        d_display = d_state == CALC ? display :
                    (d_state == RESULT || (d_state == ENTRY_B && d_count == '0)) ? d_acc : d_operand;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ENTRY_A;
            operand <= '0;
            count   <= '0;
            acc     <= '0;
            op      <= ADD;
            pend    <= ADD;
            chain   <= 1'b0;
            ovf     <= 1'b0;
            display <= '0;
        end else begin
            state   <= d_state;
            operand <= d_operand;
            count   <= d_count;
            acc     <= d_acc;
            op      <= d_op;
            pend    <= d_pend;
            chain   <= d_chain;
            ovf     <= d_ovf;
            display <= d_display;
        end
    end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed key-sequence bench for calc_sequencer with hand-computed expectations.
module tb_calc_sequencer;
    localparam int K_ADD = 16, K_MUL = 17, K_SUB = 18, K_EQ = 19, K_BS = 20, K_CA = 21;
    logic        clk, reset, newhex, newop, eq, bs, ca;
    logic [3:0]  hexcode;
    logic [1:0]  opcode;
    logic [15:0] display;
    logic        busy, ovf, entry_b;
    int          tests, fails;

    calc_sequencer dut (
        .clk(clk), .reset(reset), .newhex(newhex), .hexcode(hexcode), .newop(newop),
        .opcode(opcode), .eq(eq), .bs(bs), .ca(ca), .display(display), .busy(busy),
        .ovf(ovf), .entry_b(entry_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic key(input int k);
        @(negedge clk);
        if (k < 16) begin
            newhex  = 1'b1;
            hexcode = k[3:0];
        end else if (k == K_ADD) begin
            newop = 1'b1; opcode = 2'b00;
        end else if (k == K_MUL) begin
            newop = 1'b1; opcode = 2'b01;
        end else if (k == K_SUB) begin
            newop = 1'b1; opcode = 2'b10;
        end else if (k == K_EQ) eq = 1'b1;
        else if (k == K_BS) bs = 1'b1;
        else ca = 1'b1;
        @(negedge clk);
        newhex = 1'b0; newop = 1'b0; eq = 1'b0; bs = 1'b0; ca = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; newhex = 1'b0; newop = 1'b0; eq = 1'b0; bs = 1'b0; ca = 1'b0;
        hexcode = 4'h0; opcode = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++; if (display !== 16'h0000) begin fails++; $display("FAIL reset_display got %h want 0000", display); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", ovf); end
        tests++; if (entry_b !== 1'b0) begin fails++; $display("FAIL reset_entry_b got %b want 0", entry_b); end
    endtask

    task automatic test_add;
        int n;
        key(1); key(2); key(K_ADD);
        tests++; if (entry_b !== 1'b1 || display !== 16'h0012) begin fails++; $display("FAIL add_after_op got %b/%h want 1/0012", entry_b, display); end
        key(3); key(4);
        tests++; if (display !== 16'h0034) begin fails++; $display("FAIL add_operand_b got %h want 0034", display); end
        key(K_EQ);
        wait_idle(n);
        tests++; if (n !== 1) begin fails++; $display("FAIL add_busy_cycles got %0d want 1", n); end
        tests++; if (display !== 16'h0046 || ovf !== 1'b0) begin fails++; $display("FAIL add_result got %h/%b want 0046/0", display, ovf); end
        tests++; if (entry_b !== 1'b0) begin fails++; $display("FAIL add_entry_b got %b want 0", entry_b); end
    endtask

    task automatic test_overflow;
        int n;
        key(15); key(15); key(15); key(15); key(K_ADD); key(1); key(K_EQ);
        wait_idle(n);
        tests++; if (display !== 16'h0000 || ovf !== 1'b1) begin fails++; $display("FAIL add_carry got %h/%b want 0000/1", display, ovf); end
        key(5); key(K_SUB); key(7); key(K_EQ);
        wait_idle(n);
        tests++; if (display !== 16'hFFFE || ovf !== 1'b1) begin fails++; $display("FAIL sub_borrow got %h/%b want fffe/1", display, ovf); end
        key(9); key(K_SUB); key(4); key(K_EQ);
        wait_idle(n);
        tests++; if (display !== 16'h0005 || ovf !== 1'b0) begin fails++; $display("FAIL sub_plain got %h/%b want 0005/0", display, ovf); end
    endtask

    task automatic test_multiply;
        int n;
        key(1); key(2); key(K_MUL); key(3); key(K_EQ);
        wait_idle(n);
        tests++; if (n !== 16) begin fails++; $display("FAIL mul_busy_cycles got %0d want 16", n); end
        tests++; if (display !== 16'h0036 || ovf !== 1'b0) begin fails++; $display("FAIL mul_result got %h/%b want 0036/0", display, ovf); end
        key(1); key(2); key(K_MUL); key(3); key(K_EQ);
        repeat (7) @(negedge clk);
        tests++; if (busy !== 1'b1 || display !== 16'h0003) begin fails++; $display("FAIL mul_mid got %b/%h want 1/0003", busy, display); end
        ca = 1'b1;
        @(negedge clk);
        ca = 1'b0;
        tests++; if (busy !== 1'b0 || display !== 16'h0000 || entry_b !== 1'b0) begin fails++; $display("FAIL mul_abort got %b/%h/%b want 0/0000/0", busy, display, entry_b); end
        key(5);
        tests++; if (display !== 16'h0005 || entry_b !== 1'b0) begin fails++; $display("FAIL abort_entry_a got %h/%b want 0005/0", display, entry_b); end
        key(K_CA); key(1); key(0); key(0); key(K_MUL); key(1); key(0); key(0); key(K_EQ);
        wait_idle(n);
        tests++; if (display !== 16'h0000 || ovf !== 1'b1) begin fails++; $display("FAIL mul_ovf got %h/%b want 0000/1", display, ovf); end
    endtask

    task automatic test_digits;
        key(K_CA); key(1); key(2); key(3); key(4); key(5);
        tests++; if (display !== 16'h1234) begin fails++; $display("FAIL digit_limit got %h want 1234", display); end
        key(K_BS); key(K_BS);
        tests++; if (display !== 16'h0012) begin fails++; $display("FAIL backspace got %h want 0012", display); end
        key(K_BS); key(K_BS); key(K_BS);
        tests++; if (display !== 16'h0000) begin fails++; $display("FAIL backspace_empty got %h want 0000", display); end
        key(7);
        tests++; if (display !== 16'h0007) begin fails++; $display("FAIL no_underflow got %h want 0007", display); end
        key(K_EQ);
        tests++; if (display !== 16'h0007 || busy !== 1'b0) begin fails++; $display("FAIL eq_in_a got %h/%b want 0007/0", display, busy); end
    endtask

    task automatic test_priority;
        key(K_CA); key(1);
        @(negedge clk);
        newhex = 1'b1; hexcode = 4'h2; bs = 1'b1;
        @(negedge clk);
        newhex = 1'b0; bs = 1'b0;
        tests++; if (display !== 16'h0000) begin fails++; $display("FAIL bs_over_hex got %h want 0000", display); end
        @(negedge clk);
        newop = 1'b1; opcode = 2'b00; newhex = 1'b1; hexcode = 4'h9;
        @(negedge clk);
        newop = 1'b0; newhex = 1'b0;
        tests++; if (entry_b !== 1'b1 || display !== 16'h0000) begin fails++; $display("FAIL op_over_hex got %b/%h want 1/0000", entry_b, display); end
    endtask

    task automatic test_chain;
        int n;
        key(K_CA); key(5); key(K_ADD); key(3); key(K_SUB);
        wait_idle(n);
        tests++; if (display !== 16'h0008 || entry_b !== 1'b1 || n !== 1) begin fails++; $display("FAIL chain_mid got %h/%b/%0d want 0008/1/1", display, entry_b, n); end
        key(2); key(K_EQ);
        wait_idle(n);
        tests++; if (display !== 16'h0006) begin fails++; $display("FAIL chain_final got %h want 0006", display); end
        key(4); key(K_ADD); key(K_MUL); key(2); key(K_EQ);
        wait_idle(n);
        tests++; if (display !== 16'h0008 || n !== 16) begin fails++; $display("FAIL op_swap got %h/%0d want 0008/16", display, n); end
    endtask

    task automatic test_back_to_back;
        int n;
        key(K_ADD); key(3); key(K_EQ);
        wait_idle(n);
        tests++; if (display !== 16'h000B || ovf !== 1'b0) begin fails++; $display("FAIL result_reuse got %h/%b want 000b/0", display, ovf); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset;
        test_add;
        test_overflow;
        test_multiply;
        test_digits;
        test_priority;
        test_chain;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
